quad_encoder_gen: RTL and testbench
===================================

# quad_encoder_gen

Quadrature encoder signal generator, the transmit-side counterpart of the motor controller's encoder inputs. It emits a two-phase A/B quadrature pattern at a programmable rate, in either direction, for a programmed number of steps or continuously. It keeps a position count using the same rule the motor controller's decoder applies, so the two counts must agree. It sits on the Wishbone bus as a slave and drives encoder pins for hardware-in-the-loop testing of the motor path.

## Interface
- PERIOD_WIDTH, 24, width of the PERIOD register (sys_clk cycles per quadrature step)
- MIN_PERIOD, 64, smallest legal PERIOD; must exceed the decoder debounce depth of 48
- sys_clk  input  1  single clock for all logic
- sys_rst  input  1  synchronous, active-high reset
- enc  output  2  quadrature outputs: enc[0]=A, enc[1]=B, registered
- busy  output  1  high while the generator is stepping
- wb_cyc, wb_stb, wb_we  input  1 each  Wishbone cycle/strobe/write
- wb_adr  input  32  byte address; only [7:2] decoded
- wb_sel  input  4  byte lanes
- wb_mosi  input  32  write data
- wb_miso  output  32  read data, registered
- wb_ack, wb_err  output  1 each  registered termination

## Operation
- Register map (byte offset):
  - 0x00 CTRL, R/W: bit31 EN, bit30 DIR (1=up), bit0 CONT (free-run); other bits read 0.
  - 0x04 PERIOD, R/W: [PERIOD_WIDTH-1:0]. Writes below MIN_PERIOD store MIN_PERIOD. Upper bits read 0.
  - 0x08 STEPS, R/W: 32-bit count of quadrature transitions remaining.
  - 0x0C POS, R/W: 32-bit two's-complement position.
- Any other offset in [7:0]: wb_err. A write with wb_sel != 4'hF: wb_err, and no register changes.
- Running condition: run = EN & (CONT | STEPS != 0). busy = run.
- Phase sequence on {B,A}:
  - Up: 00→10→11→01→00.
  - Down: 00→01→11→10→00.
  - Exactly one bit changes per step.
- POS update:
  - +1 on the up transition 10→11 (A rises while B=1).
  - −1 on the down transition 00→01 (A rises while B=0).
  - No change on other transitions. Wraps modulo 2^32.
  - One full up cycle of 4 steps gives POS +1.
- Divider counter:
  - Runs 0..PERIOD−1 while run=1 and is held at 0 while run=0.
  - At the terminal count: advance one step, reset the counter to 0, and decrement STEPS if CONT=0.
- DIR is sampled at each step. A mid-run DIR change reverses from the current phase without a glitch.
- When STEPS reaches 0 (CONT=0), busy falls on the same edge as the final step and enc holds its last phase.
- Clearing EN stops the generator immediately. enc holds, and the counter is cleared.
- Simultaneous events: a bus write to STEPS, POS or PERIOD in the same cycle as a step wins over the step's update to that register. The other effects of the step still occur.
- A PERIOD write clears the divider counter.
- Wishbone handshake:
  - On cyc&stb&~ack&~err, exactly one of ack/err asserts on the next edge.
  - Write registers update on that same edge.
  - While cyc&stb stay high, ack/err hold until cyc or stb drops, then clear on the next edge.
  - No second access occurs within one strobe.

## Timing
- Reset values:
  - enc = 00, busy = 0, wb_ack = 0, wb_err = 0, wb_miso = 0.
  - CTRL = 0, PERIOD = MIN_PERIOD, STEPS = 0, POS = 0, divider = 0.
- Reset mid-run aborts immediately. The next edge produces the reset values above.
- Bus latency: 1 cycle from stb to ack/err; read data is valid in the ack cycle.
- First step: enc changes exactly PERIOD cycles after the edge that made run=1. Each further step follows PERIOD cycles later.
- POS and STEPS reflect a step on the same edge that enc changes.

## Test plan
- Reset, then read all four registers → CTRL=0, PERIOD=64, STEPS=0, POS=0; enc=00; busy=0.
- PERIOD=100, STEPS=8, CTRL=0x80000000|DIR → enc goes 10,11,01,00,10,11,01,00, each step 100 cycles apart → POS=2, STEPS=0, busy falls with the 8th step.
- From the 00 phase, down mode, STEPS=4 → enc goes 01,11,10,00 → POS decrements by 1; then write PERIOD=10 → reads back 64.
- POS=0xFFFFFFFF, 4 up steps → POS=0x00000000 (wrap); write POS in the same cycle as a counting step → the written value is kept.
- Loopback: enc wired to one motor_controller channel, PERIOD=64, 400 up steps → the controller's position read = 100 = POS; CONT mode then cleared via EN → enc frozen.
- Read 0x10 → wb_err=1, wb_ack=0; write 0x04 with wb_sel=4'h1 → wb_err, PERIOD unchanged.

Source files
------------

// File: rtl/quad_encoder_gen.sv
// -----------------------------------------------------------------------------
// quad_encoder_gen
//
// Quadrature encoder signal generator with a Wishbone slave register file.
// Emits a two-phase A/B pattern at a programmable step period, up or down,
// either for a programmed number of steps or continuously. A position count
// is kept using the same rule as the motor controller's decoder (+1 when A
// rises with B=1, -1 when A rises with B=0), so both counts agree.
//
// Registers (byte offset):
//   0x00 CTRL   bit31 EN, bit30 DIR (1=up), bit0 CONT
//   0x04 PERIOD [PERIOD_WIDTH-1:0], clamped to MIN_PERIOD on write
//   0x08 STEPS  quadrature transitions remaining
//   0x0C POS    two's-complement position
//
// Ports:
//   sys_clk, sys_rst   clock, synchronous active-high reset
//   enc[1:0]           registered quadrature outputs, enc[0]=A, enc[1]=B
//   busy               high while the generator is stepping
//   wb_cyc/stb/we      Wishbone cycle, strobe, write enable
//   wb_adr[31:0]       byte address, bits [7:2] decoded
//   wb_sel[3:0]        byte lanes; writes need all four
//   wb_mosi[31:0]      write data
//   wb_miso[31:0]      registered read data
//   wb_ack, wb_err     registered terminations
// -----------------------------------------------------------------------------
module quad_encoder_gen #(
  parameter int PERIOD_WIDTH = 24,
  parameter int MIN_PERIOD   = 64
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  output logic [1:0]  enc,
  output logic        busy,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [31:0] wb_adr,
  input  logic [3:0]  wb_sel,
  input  logic [31:0] wb_mosi,
  output logic [31:0] wb_miso,
  output logic        wb_ack,
  output logic        wb_err
);

  localparam logic [PERIOD_WIDTH-1:0] MIN_P = PERIOD_WIDTH'(MIN_PERIOD);
  localparam logic [PERIOD_WIDTH-1:0] ONE_P = PERIOD_WIDTH'(1);

  // Register file and generator state
  logic                    r_en;
  logic                    r_dir;
  logic                    r_cont;
  logic [PERIOD_WIDTH-1:0] r_period;
  logic [PERIOD_WIDTH-1:0] r_div;
  logic [31:0]             r_steps;
  logic [31:0]             r_pos;
  logic [1:0]              r_enc;
  logic                    r_busy;
  logic                    r_ack;
  logic                    r_err;
  logic [31:0]             r_miso;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic        w_req;
  logic        w_bad;
  logic        w_wr_ok;
  logic [1:0]  w_reg_sel;
  logic        w_wr_ctrl;
  logic        w_wr_period;
  logic        w_wr_steps;
  logic        w_wr_pos;
  logic [31:0] w_rd_data;
  logic        w_unused;

  // A new access is only accepted once the previous termination has dropped,
  // so a held strobe never produces a second access.
  assign w_req     = wb_cyc & wb_stb & ~r_ack & ~r_err;
  assign w_reg_sel = wb_adr[3:2];
  // Only offsets 0x00..0x0F exist; partial-lane writes are rejected whole.
  assign w_bad     = (wb_adr[7:4] != 4'd0) | (wb_we & (wb_sel != 4'hF));
  assign w_wr_ok   = w_req & wb_we & ~w_bad;

  assign w_wr_ctrl   = w_wr_ok & (w_reg_sel == 2'd0);
  assign w_wr_period = w_wr_ok & (w_reg_sel == 2'd1);
  assign w_wr_steps  = w_wr_ok & (w_reg_sel == 2'd2);
  assign w_wr_pos    = w_wr_ok & (w_reg_sel == 2'd3);

  // Address bits outside [7:2] carry no meaning here.
  assign w_unused = ^{wb_adr[31:8], wb_adr[1:0]};

  always_comb begin
    w_rd_data = 32'd0;
    case (w_reg_sel)
      2'd0:    w_rd_data = {r_en, r_dir, 29'd0, r_cont};
      2'd1:    w_rd_data = 32'(r_period);
      2'd2:    w_rd_data = r_steps;
      default: w_rd_data = r_pos;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Step generation
  // ---------------------------------------------------------------------------
  logic                    w_run;
  logic                    w_tc;
  logic                    w_step;
  logic [1:0]              w_enc_adv;
  logic                    w_pos_inc;
  logic                    w_pos_dec;
  logic                    w_en_next;
  logic                    w_cont_next;
  logic [PERIOD_WIDTH-1:0] w_period_wr;
  logic [PERIOD_WIDTH-1:0] w_period_next;
  logic [31:0]             w_steps_next;
  logic [31:0]             w_pos_next;
  logic                    w_run_next;
  logic [PERIOD_WIDTH-1:0] w_div_next;

  assign w_run  = r_en & (r_cont | (r_steps != 32'd0));
  assign w_tc   = (r_div == (r_period - ONE_P));
  assign w_step = w_run & w_tc;

  // Next phase on {B,A}. Direction is looked up from the current phase each
  // step, so a DIR change simply walks back the way it came.
  always_comb begin
    w_enc_adv = r_enc;
    if (r_dir) begin
      case (r_enc)
        2'b00:   w_enc_adv = 2'b10;
        2'b10:   w_enc_adv = 2'b11;
        2'b11:   w_enc_adv = 2'b01;
        default: w_enc_adv = 2'b00;
      endcase
    end else begin
      case (r_enc)
        2'b00:   w_enc_adv = 2'b01;
        2'b01:   w_enc_adv = 2'b11;
        2'b11:   w_enc_adv = 2'b10;
        default: w_enc_adv = 2'b00;
      endcase
    end
  end

  // A rises only on 10->11 (up, B=1) and 00->01 (down, B=0).
  assign w_pos_inc = r_dir & (r_enc == 2'b10);
  assign w_pos_dec = ~r_dir & (r_enc == 2'b00);

  assign w_en_next   = w_wr_ctrl ? wb_mosi[31] : r_en;
  assign w_cont_next = w_wr_ctrl ? wb_mosi[0] : r_cont;

  assign w_period_wr   = (wb_mosi[PERIOD_WIDTH-1:0] < MIN_P) ? MIN_P
                                                              : wb_mosi[PERIOD_WIDTH-1:0];
  assign w_period_next = w_wr_period ? w_period_wr : r_period;

  // A bus write wins over the step's own update of the same register.
  always_comb begin
    w_steps_next = r_steps;
    if (w_wr_steps) begin
      w_steps_next = wb_mosi;
    end else if (w_step & ~r_cont) begin
      w_steps_next = r_steps - 32'd1;
    end
  end

  always_comb begin
    w_pos_next = r_pos;
    if (w_wr_pos) begin
      w_pos_next = wb_mosi;
    end else if (w_step & w_pos_inc) begin
      w_pos_next = r_pos + 32'd1;
    end else if (w_step & w_pos_dec) begin
      w_pos_next = r_pos - 32'd1;
    end
  end

  assign w_run_next = w_en_next & (w_cont_next | (w_steps_next != 32'd0));

  // The divider only counts while the generator was running and stays
  // running; an edge that starts a run, ends a run, completes a step or
  // rewrites PERIOD leaves it at 0, so the next step is a full PERIOD away.
  assign w_div_next = (w_run & w_run_next & ~w_wr_period & ~w_tc) ? (r_div + ONE_P)
                                                                   : '0;

  // ---------------------------------------------------------------------------
  // State update
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_en     <= 1'b0;
      r_dir    <= 1'b0;
      r_cont   <= 1'b0;
      r_period <= MIN_P;
      r_div    <= '0;
      r_steps  <= 32'd0;
      r_pos    <= 32'd0;
      r_enc    <= 2'b00;
      r_busy   <= 1'b0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_miso   <= 32'd0;
    end else begin
      r_en     <= w_en_next;
      r_cont   <= w_cont_next;
      if (w_wr_ctrl) begin
        r_dir <= wb_mosi[30];
      end
      r_period <= w_period_next;
      r_steps  <= w_steps_next;
      r_pos    <= w_pos_next;
      r_div    <= w_div_next;
      r_busy   <= w_run_next;
      if (w_step) begin
        r_enc <= w_enc_adv;
      end

      // Termination holds while the master keeps cyc&stb high.
      if (w_req) begin
        r_ack  <= ~w_bad;
        r_err  <= w_bad;
        r_miso <= w_bad ? 32'd0 : w_rd_data;
      end else if (~(wb_cyc & wb_stb)) begin
        r_ack <= 1'b0;
        r_err <= 1'b0;
      end
    end
  end

  assign enc     = r_enc;
  assign busy    = r_busy;
  assign wb_ack  = r_ack;
  assign wb_err  = r_err;
  assign wb_miso = r_miso;

endmodule

// File: tb/tb_quad_encoder_gen.sv
// -----------------------------------------------------------------------------
// tb_quad_encoder_gen
//
// Self-checking bench for quad_encoder_gen. A behavioural model tracks the
// register file, the phase index and the absolute cycle of the next step; a
// compare process checks enc/busy/ack/err (and read data) every cycle.
// Directed sequences pin the model with hand-computed literals, then a
// randomized phase exercises writes, reads, bad accesses and resets.
// -----------------------------------------------------------------------------
module tb_quad_encoder_gen;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [1:0]  enc;
  logic        busy;
  logic        wb_cyc = 1'b0;
  logic        wb_stb = 1'b0;
  logic        wb_we  = 1'b0;
  logic [31:0] wb_adr = 32'd0;
  logic [3:0]  wb_sel = 4'h0;
  logic [31:0] wb_mosi = 32'd0;
  logic [31:0] wb_miso;
  logic        wb_ack;
  logic        wb_err;

  always #5 sys_clk = ~sys_clk;

  quad_encoder_gen #(.PERIOD_WIDTH(24), .MIN_PERIOD(64)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .enc     (enc),
    .busy    (busy),
    .wb_cyc  (wb_cyc),
    .wb_stb  (wb_stb),
    .wb_we   (wb_we),
    .wb_adr  (wb_adr),
    .wb_sel  (wb_sel),
    .wb_mosi (wb_mosi),
    .wb_miso (wb_miso),
    .wb_ack  (wb_ack),
    .wb_err  (wb_err)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned cyc_cnt  = 0;
  bit          started  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: phase index 0..3 walks the up-order 00,10,11,01.
  // ---------------------------------------------------------------------------
  bit          m_en = 0, m_dir = 0, m_cont = 0;
  logic [23:0] m_period = 24'd64;
  logic [31:0] m_steps = 32'd0, m_pos = 32'd0;
  int          m_phase = 0;
  longint      m_next_t = 0;
  bit          m_ack = 0, m_err = 0, m_rd = 0;
  logic [31:0] m_miso = 32'd0;

  function automatic logic [1:0] phase_bits(input int idx);
    case (idx)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic bit m_running();
    return m_en && (m_cont || m_steps != 32'd0);
  endfunction

  task automatic model_edge();
    bit          run, step, req, bad, pw;
    logic [31:0] rd;
    longint      t;
    cyc_cnt++;
    t = longint'(cyc_cnt);
    if (sys_rst) begin
      m_en = 0; m_dir = 0; m_cont = 0; m_period = 24'd64;
      m_steps = 0; m_pos = 0; m_phase = 0;
      m_ack = 0; m_err = 0; m_rd = 0; m_miso = 0;
      return;
    end
    run  = m_running();
    step = run && (t == m_next_t);
    req  = wb_cyc && wb_stb && !m_ack && !m_err;
    bad  = (wb_adr[7:0] >= 8'h10) || (wb_we && wb_sel != 4'hF);
    case (wb_adr[3:2])
      2'd0:    rd = {m_en, m_dir, 29'd0, m_cont};
      2'd1:    rd = {8'd0, m_period};
      2'd2:    rd = m_steps;
      default: rd = m_pos;
    endcase
    if (step) begin
      if (m_dir) begin
        if (m_phase == 1) m_pos = m_pos + 1;
        m_phase = (m_phase + 1) % 4;
      end else begin
        if (m_phase == 0) m_pos = m_pos - 1;
        m_phase = (m_phase + 3) % 4;
      end
      if (!m_cont) m_steps = m_steps - 1;
    end
    pw = 0;
    if (req) begin
      m_ack = !bad;
      m_err = bad;
      m_rd  = !wb_we;
      if (!bad) m_miso = rd;
      if (!bad && wb_we) begin
        case (wb_adr[3:2])
          2'd0: begin m_en = wb_mosi[31]; m_dir = wb_mosi[30]; m_cont = wb_mosi[0]; end
          2'd1: begin m_period = (wb_mosi[23:0] < 24'd64) ? 24'd64 : wb_mosi[23:0]; pw = 1; end
          2'd2: m_steps = wb_mosi;
          default: m_pos = wb_mosi;
        endcase
      end
    end else if (!(wb_cyc && wb_stb)) begin
      m_ack = 0;
      m_err = 0;
    end
    if (m_running() && (!run || pw || step)) m_next_t = t + longint'(m_period);
  endtask

  initial forever begin
    @(posedge sys_clk);
    model_edge();
  end

  // Compare process
  initial forever begin
    @(negedge sys_clk);
    if (started) begin
      chk("outputs{enc,busy,ack,err}", {27'd0, enc, busy, wb_ack, wb_err},
          {27'd0, phase_bits(m_phase), m_running(), m_ack, m_err});
      if (m_ack && m_rd) chk("read_data", wb_miso, m_miso);
    end
  end

  // Monitor: records enc transitions and runs a reference decoder.
  logic [1:0]  q_val[$];
  int unsigned q_t[$];
  bit          q_busy[$];
  logic [1:0]  prev_enc = 2'b00;
  int          dec_cnt = 0;

  initial forever begin
    @(negedge sys_clk);
    if (sys_rst) begin
      dec_cnt  = 0;
      prev_enc = 2'b00;
    end else if (started) begin
      if (enc !== prev_enc) begin
        q_val.push_back(enc);
        q_t.push_back(cyc_cnt);
        q_busy.push_back(busy);
        if (!prev_enc[0] && enc[0]) dec_cnt += enc[1] ? 1 : -1;
      end
      prev_enc = enc;
    end
  end

  // ---------------------------------------------------------------------------
  // Bus helpers
  // ---------------------------------------------------------------------------
  task automatic xfer(input bit we, input logic [31:0] adr, input logic [31:0] data,
                      input logic [3:0] sel, input bit now,
                      output logic [31:0] rdata, output bit ack, output bit err,
                      output int unsigned t_ack);
    bit done = 0;
    if (!now) begin
      @(posedge sys_clk);
      #1;
    end
    wb_cyc = 1; wb_stb = 1; wb_we = we; wb_adr = adr; wb_sel = sel; wb_mosi = data;
    for (int i = 0; i < 8 && !done; i++) begin
      @(negedge sys_clk);
      if (wb_ack || wb_err) begin
        done = 1; ack = wb_ack; err = wb_err; rdata = wb_miso; t_ack = cyc_cnt;
      end
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL bus_timeout: no ack/err within 8 cycles, adr 0x%08h", adr);
      ack = 0; err = 0; rdata = 0; t_ack = cyc_cnt;
    end
    @(posedge sys_clk);
    #1;
    wb_cyc = 0; wb_stb = 0; wb_we = 0;
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] data, output int unsigned t);
    logic [31:0] d; bit a, e;
    xfer(1'b1, adr, data, 4'hF, 1'b0, d, a, e, t);
    $display("WR  adr=0x%02h data=0x%08h ack=%0d err=%0d t=%0d", adr[7:0], data, a, e, t);
  endtask

  task automatic rd(input logic [31:0] adr, output logic [31:0] data);
    bit a, e; int unsigned t;
    xfer(1'b0, adr, 32'd0, 4'hF, 1'b0, data, a, e, t);
    $display("RD  adr=0x%02h data=0x%08h ack=%0d err=%0d t=%0d", adr[7:0], data, a, e, t);
  endtask

  task automatic pulse_reset();
    @(posedge sys_clk); #1;
    sys_rst = 1;
    @(posedge sys_clk); #1;
    sys_rst = 0;
    $display("RST t=%0d", cyc_cnt);
  endtask

  task automatic check_steps(input string name, input int base, input int n,
                             input int unsigned t0, input int period,
                             input logic [1:0] exp_cycle [4]);
    chk({name, "_count"}, q_val.size() - base, n);
    if (q_val.size() - base == n) begin
      for (int i = 0; i < n; i++) begin
        chk({name, "_phase"}, {30'd0, q_val[base+i]}, {30'd0, exp_cycle[i%4]});
        chk({name, "_gap"}, q_t[base+i] - ((i == 0) ? t0 : q_t[base+i-1]), period);
      end
      chk({name, "_busy_last"}, {31'd0, q_busy[base+n-1]}, 32'd0);
      chk({name, "_busy_prev"}, {31'd0, q_busy[base+n-2]}, 32'd1);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [1:0] exp_up [4]   = '{2'b10, 2'b11, 2'b01, 2'b00};
  logic [1:0] exp_down [4] = '{2'b01, 2'b11, 2'b10, 2'b00};

  initial begin
    logic [31:0] d;
    int unsigned t, t2;
    int          base, found;
    logic [1:0]  frozen;
    bit          a, e;

    @(posedge sys_clk);
    #1;
    started = 1;
    @(posedge sys_clk); #1;
    sys_rst = 0;

    // Reset state
    chk("rst_enc", {30'd0, enc}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rd(32'h00, d); chk("rst_ctrl", d, 32'h0000_0000);
    rd(32'h04, d); chk("rst_period", d, 32'd64);
    rd(32'h08, d); chk("rst_steps", d, 32'd0);
    rd(32'h0C, d); chk("rst_pos", d, 32'd0);

    // 8 up steps at PERIOD=100
    wr(32'h04, 32'd100, t);
    wr(32'h08, 32'd8, t);
    base = q_val.size();
    wr(32'h00, 32'hC000_0000, t);
    repeat (8 * 100 + 20) @(posedge sys_clk);
    check_steps("up8", base, 8, t, 100, exp_up);
    rd(32'h0C, d); chk("up8_pos", d, 32'd2);
    rd(32'h08, d); chk("up8_steps", d, 32'd0);

    // 4 down steps from 00
    wr(32'h00, 32'h8000_0000, t);
    base = q_val.size();
    wr(32'h08, 32'd4, t);
    repeat (4 * 100 + 20) @(posedge sys_clk);
    check_steps("down4", base, 4, t, 100, exp_down);
    rd(32'h0C, d); chk("down4_pos", d, 32'd1);
    wr(32'h04, 32'd10, t);
    rd(32'h04, d); chk("period_clamp", d, 32'd64);

    // POS wrap
    wr(32'h0C, 32'hFFFF_FFFF, t);
    wr(32'h00, 32'hC000_0000, t);
    wr(32'h08, 32'd4, t);
    repeat (4 * 64 + 20) @(posedge sys_clk);
    rd(32'h0C, d); chk("pos_wrap", d, 32'h0000_0000);

    // POS write lands on the same edge as the counting 10->11 step
    wr(32'h08, 32'd100, t);
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      @(negedge sys_clk);
      if (enc == 2'b10) found = 1;
    end
    chk("collide_found", found, 1);
    repeat (63) @(posedge sys_clk);
    #1;
    xfer(1'b1, 32'h0C, 32'h1234_5678, 4'hF, 1'b1, d, a, e, t2);
    $display("WR  adr=0x0c data=0x12345678 ack=%0d err=%0d t=%0d (on step edge)", a, e, t2);
    chk("collide_enc", {30'd0, enc}, {30'd0, 2'b11});
    rd(32'h0C, d); chk("collide_pos", d, 32'h1234_5678);
    wr(32'h00, 32'h0, t);

    // Loopback: 400 up steps against the reference decoder
    pulse_reset();
    wr(32'h04, 32'd64, t);
    wr(32'h00, 32'hC000_0000, t);
    wr(32'h08, 32'd400, t);
    repeat (400 * 64 + 20) @(posedge sys_clk);
    chk("loop_decoder", dec_cnt, 100);
    rd(32'h0C, d); chk("loop_pos", d, 32'd100);
    chk("loop_busy", {31'd0, busy}, 32'd0);

    // Continuous mode, then stop via EN
    base = q_val.size();
    wr(32'h00, 32'hC000_0001, t);
    repeat (300) @(posedge sys_clk);
    wr(32'h00, 32'h0, t);
    chk("cont_moved", (q_val.size() - base >= 4) ? 1 : 0, 1);
    frozen = enc;
    repeat (200) @(posedge sys_clk);
    chk("cont_frozen", {30'd0, enc}, {30'd0, frozen});
    chk("cont_busy", {31'd0, busy}, 32'd0);

    // Error terminations
    xfer(1'b0, 32'h10, 32'd0, 4'hF, 1'b0, d, a, e, t);
    $display("RD  adr=0x10 ack=%0d err=%0d", a, e);
    chk("bad_adr_err", {31'd0, e}, 32'd1);
    chk("bad_adr_ack", {31'd0, a}, 32'd0);
    xfer(1'b1, 32'h04, 32'd200, 4'h1, 1'b0, d, a, e, t);
    $display("WR  adr=0x04 sel=1 ack=%0d err=%0d", a, e);
    chk("bad_sel_err", {31'd0, e}, 32'd1);
    rd(32'h04, d); chk("bad_sel_period", d, 32'd64);

    // Randomized traffic, checked cycle by cycle against the model
    for (int n = 0; n < 150; n++) begin
      int unsigned r;
      logic [31:0] v;
      r = $urandom_range(0, 99);
      if (r < 8) begin
        pulse_reset();
      end else if (r < 30) begin
        wr(32'h04, $urandom_range(0, 120), t);
      end else if (r < 50) begin
        wr(32'h08, $urandom_range(0, 12), t);
      end else if (r < 70) begin
        v = $urandom;
        v[31] = ($urandom_range(0, 3) != 0);
        v[0]  = ($urandom_range(0, 7) == 0);
        wr(32'h00, v, t);
      end else if (r < 80) begin
        wr(32'h0C, $urandom, t);
      end else if (r < 90) begin
        rd({28'd0, 2'($urandom_range(0, 3)), 2'b00}, d);
      end else begin
        v = $urandom;
        xfer(1'($urandom_range(0, 1)), {v[31:8], 8'($urandom_range(0, 31))}, $urandom,
             4'($urandom_range(0, 15)), 1'b0, d, a, e, t);
        $display("RND adr=0x%08h ack=%0d err=%0d", wb_adr, a, e);
      end
      repeat ($urandom_range(0, 300)) @(posedge sys_clk);
    end

    @(negedge sys_clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
